pe_row_conv: RTL and testbench
==============================

# pe_row_conv

Parametrised weight-stationary 1-D convolution row: K processing elements hold one filter tap each, activations stream through a transposed-form accumulation chain, and one partial sum emerges per valid window. It is the generalised successor of the fixed 8-wide PE row, adding configurable width and tap count, signed/unsigned mode, ready/valid handshakes, an upstream psum input for cross-channel accumulation, and job framing with a job-done pulse. It sits between the activation/weight buffers and the channel accumulator of the conv engine.

## Interface
- DW, 8, activation/weight width
- K, 8, taps (PE count), ≥2
- ACCW, 2*DW+4, psum width
- LENW, 16, width of job length
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low (one clock; async active-low reset is fixed)
- en  in  1  global enable; 0 freezes all state, handshakes deasserted
- i_start  in  1  job start pulse (honoured in IDLE only)
- i_len  in  LENW  input samples N for the job, sampled on start
- i_signed  in  1  1 = two's-complement operands, sampled on start
- i_w_valid / o_w_ready  in/out  1  weight handshake
- i_w  in  DW  weight; first accepted = w[0]
- i_x_valid / o_x_ready  in/out  1  activation handshake
- i_x  in  DW  activation sample
- i_psum  in  ACCW  upstream partial sum, sampled with each accepted x
- o_psum  out  ACCW  output partial sum
- o_psum_valid  out  1  o_psum qualifier, one-cycle pulse per output
- end_pe  out  1  one-cycle pulse: job finished
- o_busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → LOAD_W → RUN → IDLE.
- IDLE: start with N ≥ K → LOAD_W, latch N and mode, clear chain registers. Start with N < K → stay IDLE, pulse end_pe next cycle, no outputs.
- LOAD_W: o_w_ready=1; each handshake writes next tap (w[0]..w[K-1]); after K-th → RUN.
- RUN: o_x_ready=1; each handshake shifts the chain. Sample index n counts 0..N-1.
- Output: y[n] = Σ_{k=0..K-1} w[k]·x[n−k] + i_psum(n), emitted for n ≥ K−1 only; N−K+1 outputs per job.
- Chain (transposed form): r[K-1] ← w[K-1]·x; r[k] ← w[k]·x + r[k+1]; o_psum ← w[0]·x + r[1] + i_psum.
- Arithmetic: products 2*DW, sign- or zero-extended per i_signed to ACCW; sums wrap modulo 2^ACCW, no saturation.
- After N-th accepted sample → IDLE; end_pe coincides with last o_psum_valid.
- Weights persist after job; next job reloads them.

## Timing
- Reset values: o_psum=0, o_psum_valid=0, end_pe=0, o_busy=0, o_w_ready=0, o_x_ready=0, state IDLE, taps and chain 0.
- Latency: o_psum_valid one cycle after the accepting edge of x[n], n ≥ K−1.
- Handshake: transfer on rising edge with valid & ready & en; ready is state-decoded (combinational from state and en).
- Valid gap: chain holds, no output; no bubble insertion.
- en=0: every register holds, including pulse outputs (pulses stretch by the freeze); readies forced 0.
- start in LOAD_W/RUN: ignored.
- rstn low mid-job: immediate return to reset values; no end_pe.
- N=K: exactly one output, end_pe with it.

## Structure
- Package `definition`: add pe_state_t enum (PE_IDLE, PE_LOAD_W, PE_RUN) and default constants PE_DW, PE_K, PE_ACCW.
- Sub-module pe_cell: one tap register, signed/unsigned multiplier, adder into chain register; generate K instances.
- Top: FSM, tap-load pointer, sample counter, output register.

## Test plan
- Unsigned, K=8, weights all 1, N=10, x=1..10, psum=0 → outputs 36, 44, 52; end_pe with 52.
- Signed, weights 0xFF (−1), x=2 constant, N=8 → single output −16 (0xFFFF0 at ACCW=20).
- i_psum=100 on every x, same as scenario 1 → 136, 144, 152.
- Toggle i_x_valid 1/0 every cycle, scenario 1 data → same three values, each output one cycle after its accepting edge.
- en=0 for 5 cycles mid-RUN → all outputs/state frozen, results identical to scenario 1; N=5 start → end_pe next cycle, no o_psum_valid.
- rstn low after 4 samples → outputs reset, o_busy=0; fresh job afterward produces correct values.

Source files
------------

// File: rtl/pe_row_conv_pkg.sv
// Shared types and default sizes for the weight-stationary convolution row.
package definition;

  typedef enum logic [1:0] {
    PE_IDLE,
    PE_LOAD_W,
    PE_RUN
  } pe_state_t;

  localparam int PE_DW   = 8;
  localparam int PE_K    = 8;
  localparam int PE_ACCW = 2 * PE_DW + 4;

endpackage

// File: rtl/pe_row_conv_pe_cell.sv
// One tap of the transposed-form chain: stationary weight, multiplier and
// accumulating chain register.
module pe_cell
  import definition::*;
#(
  parameter int DW   = PE_DW,
  parameter int ACCW = PE_ACCW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            w_we,
  input  logic [DW-1:0]   w,
  input  logic            clr,
  input  logic            shift,
  input  logic            sgn,
  input  logic [DW-1:0]   x,
  input  logic [ACCW-1:0] acc_in,
  output logic [ACCW-1:0] acc_o
);

  logic [DW-1:0]          tap_q;
  logic [ACCW-1:0]        acc_q;
  logic signed [ACCW-1:0] prod;

  // Extending both operands to ACCW before multiplying yields the exact
  // 2*DW product reduced modulo 2^ACCW, which is all the chain keeps.
  function automatic logic signed [ACCW-1:0] ext(input logic [DW-1:0] v, input logic s);
    return {{(ACCW-DW){s & v[DW-1]}}, v};
  endfunction

  assign prod  = ext(tap_q, sgn) * ext(x, sgn);
  assign acc_o = acc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tap_q <= '0;
      acc_q <= '0;
    end else begin
      if (w_we) tap_q <= w;
      if (clr)        acc_q <= '0;
      else if (shift) acc_q <= prod + acc_in;
    end
  end

endmodule

// File: rtl/pe_row_conv.sv
// Weight-stationary 1-D convolution row: K taps, transposed accumulation
// chain, job framing with load/run phases and a job-done pulse.
module pe_row_conv
  import definition::*;
#(
  parameter int DW   = PE_DW,
  parameter int K    = PE_K,
  parameter int ACCW = PE_ACCW,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            i_start,
  input  logic [LENW-1:0] i_len,
  input  logic            i_signed,
  input  logic            i_w_valid,
  output logic            o_w_ready,
  input  logic [DW-1:0]   i_w,
  input  logic            i_x_valid,
  output logic            o_x_ready,
  input  logic [DW-1:0]   i_x,
  input  logic [ACCW-1:0] i_psum,
  output logic [ACCW-1:0] o_psum,
  output logic            o_psum_valid,
  output logic            end_pe,
  output logic            o_busy
);

  localparam int              WPW    = $clog2(K);
  localparam logic [LENW-1:0] K_LEN  = LENW'(K);
  localparam logic [LENW-1:0] K_M1   = LENW'(K - 1);
  localparam logic [WPW-1:0]  K_LAST = WPW'(K - 1);

  pe_state_t       state_q, state_d;
  logic [WPW-1:0]  wptr_q;
  logic [LENW-1:0] len_q, cnt_q;
  logic            sgn_q, vld_q, end_q;
  logic            w_fire, x_fire, start_ok, start_short, last_x;
  logic [ACCW-1:0] acc [K];

  assign o_w_ready   = en && (state_q == PE_LOAD_W);
  assign o_x_ready   = en && (state_q == PE_RUN);
  assign w_fire      = o_w_ready && i_w_valid;
  assign x_fire      = o_x_ready && i_x_valid;
  assign start_ok    = en && i_start && (state_q == PE_IDLE) && (i_len >= K_LEN);
  assign start_short = en && i_start && (state_q == PE_IDLE) && (i_len < K_LEN);
  assign last_x      = x_fire && (cnt_q == len_q - LENW'(1));

  assign o_psum       = acc[0];
  assign o_psum_valid = vld_q;
  assign end_pe       = end_q;
  assign o_busy       = (state_q != PE_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      PE_IDLE:   if (start_ok) state_d = PE_LOAD_W;
      PE_LOAD_W: if (w_fire && (wptr_q == K_LAST)) state_d = PE_RUN;
      PE_RUN:    if (last_x) state_d = PE_IDLE;
      default:   state_d = PE_IDLE;
    endcase
  end

  // Control registers; every one of them freezes while en is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= PE_IDLE;
      wptr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      vld_q   <= 1'b0;
      end_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      vld_q   <= x_fire && (cnt_q >= K_M1);
      end_q   <= last_x || start_short;
      if (start_ok) begin
        len_q  <= i_len;
        sgn_q  <= i_signed;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (w_fire) wptr_q <= wptr_q + WPW'(1);
        if (x_fire) cnt_q  <= cnt_q + LENW'(1);
      end
    end
  end

  // Tap K-1 starts the chain from zero; tap 0 folds in the upstream psum.
  for (genvar k = 0; k < K; k++) begin : g_pe
    logic [ACCW-1:0] chain_in;
    if (k == K - 1) begin : g_tail
      assign chain_in = '0;
    end else if (k == 0) begin : g_head
      assign chain_in = acc[1] + i_psum;
    end else begin : g_mid
      assign chain_in = acc[k+1];
    end

    pe_cell #(.DW(DW), .ACCW(ACCW)) u_cell (
      .clk    (clk),
      .rstn   (rstn),
      .w_we   (w_fire && (wptr_q == WPW'(k))),
      .w      (i_w),
      .clr    (start_ok),
      .shift  (x_fire),
      .sgn    (sgn_q),
      .x      (i_x),
      .acc_in (chain_in),
      .acc_o  (acc[k])
    );
  end

endmodule

// File: tb/tb_pe_row_conv.sv
// Randomised and directed bench for pe_row_conv against a behavioural model.
module tb_pe_row_conv;
  localparam int DW = 8, K = 8, ACCW = 20, LENW = 16;

  logic            clk = 1'b0, rstn = 1'b1, en = 1'b1;
  logic            i_start = 1'b0, i_signed = 1'b0, i_w_valid = 1'b0, i_x_valid = 1'b0;
  logic [LENW-1:0] i_len = '0;
  logic [DW-1:0]   i_w = '0, i_x = '0;
  logic [ACCW-1:0] i_psum = '0;
  logic            o_w_ready, o_x_ready, o_psum_valid, end_pe, o_busy;
  logic [ACCW-1:0] o_psum;

  int n_tests = 0, n_fail = 0;

  // Model state
  int              phase = 0, wcnt = 0, xcnt = 0, mlen = 0;
  bit              msgn = 1'b0, exp_vld = 1'b0, exp_end = 1'b0;
  logic [DW-1:0]   wm [K];
  logic [DW-1:0]   xh [$];
  logic [ACCW-1:0] exp_psum = '0;
  logic [ACCW-1:0] got [$];

  // Stimulus tables
  logic [DW-1:0]   wv [K];
  logic [DW-1:0]   xv [$];
  logic [ACCW-1:0] pv [$];

  pe_row_conv #(.DW(DW), .K(K), .ACCW(ACCW), .LENW(LENW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .i_start(i_start), .i_len(i_len),
    .i_signed(i_signed), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w(i_w),
    .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .i_x(i_x), .i_psum(i_psum),
    .o_psum(o_psum), .o_psum_valid(o_psum_valid), .end_pe(end_pe), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  function automatic longint prod(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit s);
    if (s) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  // Called at a falling edge with this cycle's inputs applied.
  task automatic cycle();
    longint acc;
    #1;
    check_eq("w_ready", o_w_ready, en && phase == 1);
    check_eq("x_ready", o_x_ready, en && phase == 2);
    check_eq("busy", o_busy, phase != 0);
    if (en) begin
      exp_vld = 1'b0;
      exp_end = 1'b0;
      case (phase)
        0: if (i_start) begin
             if (i_len >= K) begin
               phase = 1; mlen = i_len; msgn = i_signed; wcnt = 0; xcnt = 0; xh.delete();
             end else exp_end = 1'b1;
           end
        1: if (i_w_valid) begin
             wm[wcnt] = i_w; wcnt++;
             if (wcnt == K) phase = 2;
           end
        2: if (i_x_valid) begin
             xh.push_back(i_x);
             if (xcnt >= K - 1) begin
               acc = longint'(i_psum);
               for (int k = 0; k < K; k++) acc += prod(wm[k], xh[xcnt-k], msgn);
               exp_psum = acc[ACCW-1:0];
               exp_vld  = 1'b1;
             end
             xcnt++;
             if (xcnt == mlen) begin phase = 0; exp_end = 1'b1; end
           end
        default: ;
      endcase
    end
    @(negedge clk);
    check_eq("psum_valid", o_psum_valid, exp_vld);
    check_eq("end_pe", end_pe, exp_end);
    if (exp_vld) check_eq("psum", o_psum, exp_psum);
    if (en && o_psum_valid) got.push_back(o_psum);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_eq("rst_psum", o_psum, 0);
    check_eq("rst_valid", o_psum_valid, 0);
    check_eq("rst_end", end_pe, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_w_ready", o_w_ready, 0);
    check_eq("rst_x_ready", o_x_ready, 0);
    phase = 0; exp_vld = 1'b0; exp_end = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // gap: 0 none, 1 toggle valid, 2 random idle cycles
  task automatic job(input int n, input bit s, input int gap, input int freeze_at, input int abort_at);
    got.delete();
    i_start = 1'b1; i_len = LENW'(n); i_signed = s;
    cycle();
    i_start = 1'b0;
    for (int k = 0; k < K; k++) begin
      i_w_valid = 1'b1; i_w = wv[k];
      cycle();
      if (gap == 2 && $urandom_range(1) == 1) begin
        i_w_valid = 1'b0; i_w = DW'($urandom); cycle();
      end
    end
    i_w_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        i_x_valid = 1'b0;
        do_reset();
        return;
      end
      i_x = xv[i]; i_psum = pv[i]; i_x_valid = 1'b1;
      if (i == freeze_at) begin
        en = 1'b0; repeat (5) cycle(); en = 1'b1;
      end
      cycle();
      if (gap == 1 || (gap == 2 && $urandom_range(1) == 1)) begin
        i_x_valid = 1'b0; i_x = DW'($urandom); cycle();
      end
    end
    i_x_valid = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic fill_ramp(input int n, input logic [ACCW-1:0] p);
    for (int k = 0; k < K; k++) wv[k] = DW'(1);
    xv.delete(); pv.delete();
    for (int i = 0; i < n; i++) begin xv.push_back(DW'(i + 1)); pv.push_back(p); end
  endtask

  task automatic check_got3(input string tag, input logic [ACCW-1:0] a,
                            input logic [ACCW-1:0] b, input logic [ACCW-1:0] c);
    check_eq({tag, "_count"}, got.size(), 3);
    if (got.size() == 3) begin
      check_eq({tag, "_y0"}, got[0], a);
      check_eq({tag, "_y1"}, got[1], b);
      check_eq({tag, "_y2"}, got[2], c);
    end
  endtask

  initial begin
    #1;
    do_reset();

    fill_ramp(10, '0);
    job(10, 1'b0, 0, -1, -1);
    check_got3("s1_unsigned", 36, 44, 52);

    for (int k = 0; k < K; k++) wv[k] = 8'hFF;
    xv.delete(); pv.delete();
    for (int i = 0; i < 8; i++) begin xv.push_back(8'd2); pv.push_back('0); end
    job(8, 1'b1, 0, -1, -1);
    check_eq("s2_count", got.size(), 1);
    if (got.size() == 1) check_eq("s2_signed", got[0], 20'hFFFF0);

    fill_ramp(10, 100);
    job(10, 1'b0, 0, -1, -1);
    check_got3("s3_psum", 136, 144, 152);

    fill_ramp(10, '0);
    job(10, 1'b0, 1, -1, -1);
    check_got3("s4_toggle", 36, 44, 52);

    job(10, 1'b0, 0, 8, -1);
    check_got3("s5_freeze", 36, 44, 52);

    got.delete();
    i_start = 1'b1; i_len = LENW'(5);
    cycle();
    i_start = 1'b0;
    repeat (2) cycle();
    check_eq("short_no_output", got.size(), 0);

    job(10, 1'b0, 0, -1, 4);
    job(10, 1'b0, 0, -1, -1);
    check_got3("s6_after_reset", 36, 44, 52);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(K, 20);
      for (int k = 0; k < K; k++) wv[k] = DW'($urandom);
      xv.delete(); pv.delete();
      for (int i = 0; i < n; i++) begin
        xv.push_back(DW'($urandom));
        pv.push_back(ACCW'($urandom));
      end
      job(n, 1'($urandom_range(1)), 2, $urandom_range(0, n - 1), -1);
      check_eq("rand_count", got.size(), n - K + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
